// File: rtl/mem_line_arbiter_pkg.sv
// Shared types for the line-wide memory port arbiter.
package mem_line_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {ARB_OP_READ, ARB_OP_WRITE} arb_op_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first pending index scanning upward from last_i+1 with wrap.
module rr_priority_picker #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    pending_i,
  input  logic [IdxW-1:0] last_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  logic [31:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last_i) + i) % N;
      if (!found_o && pending_i[cand[IdxW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between NB_PORTS L1 requesters,
// with a per-transaction timeout and a sticky error flag.
module mem_line_arbiter
  import mem_line_arbiter_pkg::*;
#(
  parameter int unsigned NB_PORTS       = 3,
  parameter int unsigned LINE_SIZE      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned IdW = $clog2(NB_PORTS)
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [NB_PORTS-1:0]                 req_read_en_i,
  input  logic [NB_PORTS-1:0]                 req_write_en_i,
  input  logic [NB_PORTS-1:0][31:0]           req_addr_i,
  input  logic [NB_PORTS-1:0][LINE_SIZE-1:0]  req_write_data_i,
  output logic [NB_PORTS-1:0]                 req_read_valid_o,
  output logic [NB_PORTS-1:0]                 req_write_valid_o,
  output logic [LINE_SIZE-1:0]                req_read_data_o,
  output logic                                mem_read_en_o,
  output logic                                mem_write_en_o,
  output logic [31:0]                         mem_addr_o,
  output logic [LINE_SIZE-1:0]                mem_write_data_o,
  input  logic                                mem_read_valid_i,
  input  logic                                mem_write_valid_i,
  input  logic [LINE_SIZE-1:0]                mem_read_data_i,
  output logic [IdW-1:0]                      grant_id_o,
  output logic                                timeout_err_o
);

  localparam int unsigned CntW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  arb_state_t           state_q, state_d;
  arb_op_t              op_q, op_d;
  logic [IdW-1:0]       grant_q, grant_d;
  logic [IdW-1:0]       last_q, last_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_SIZE-1:0] wdata_q, wdata_d;
  logic [LINE_SIZE-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 pick_found;
  logic [IdW-1:0]       pick_idx;
  logic                 mem_done;
  logic                 tmo;

  rr_priority_picker #(
    .N (NB_PORTS)
  ) u_picker (
    .pending_i (req_read_en_i | req_write_en_i),
    .last_i    (last_q),
    .found_o   (pick_found),
    .idx_o     (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mem_done = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = pick_idx;
          // Write wins when both are raised; the read is re-arbitrated later.
          op_d    = req_write_en_i[pick_idx] ? ARB_OP_WRITE : ARB_OP_READ;
          addr_d  = req_addr_i[pick_idx];
          wdata_d = req_write_data_i[pick_idx];
          cnt_d   = '0;
        end
      end
      ARB_BUSY: begin
        mem_done = (op_q == ARB_OP_READ) ? mem_read_valid_i : mem_write_valid_i;
        tmo      = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TimeoutLast));
        if (mem_done) begin
          rdata_d = (op_q == ARB_OP_READ) ? mem_read_data_i : '0;
          state_d = ARB_RESP;
        end else if (tmo) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_RESP: begin
        last_d  = grant_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ARB_IDLE;
      op_q    <= ARB_OP_READ;
      grant_q <= '0;
      last_q  <= IdW'(NB_PORTS - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem_read_en_o     = (state_q == ARB_BUSY) && (op_q == ARB_OP_READ);
    mem_write_en_o    = (state_q == ARB_BUSY) && (op_q == ARB_OP_WRITE);
    req_read_valid_o  = '0;
    req_write_valid_o = '0;
    if (state_q == ARB_RESP) begin
      if (op_q == ARB_OP_READ) req_read_valid_o  = NB_PORTS'(1) << grant_q;
      else                     req_write_valid_o = NB_PORTS'(1) << grant_q;
    end
    mem_addr_o       = addr_q;
    mem_write_data_o = wdata_q;
    req_read_data_o  = rdata_q;
    grant_id_o       = grant_q;
    timeout_err_o    = err_q;
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed self-checking bench for mem_line_arbiter (3 ports, 256-bit lines, 16-cycle timeout).
module tb_mem_line_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned LS = 256;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NP-1:0]      req_read_en;
  logic [NP-1:0]      req_write_en;
  logic [NP-1:0][31:0] req_addr;
  logic [NP-1:0][LS-1:0] req_wdata;
  logic [NP-1:0]      req_read_valid;
  logic [NP-1:0]      req_write_valid;
  logic [LS-1:0]      req_read_data;
  logic               mem_read_en;
  logic               mem_write_en;
  logic [31:0]        mem_addr;
  logic [LS-1:0]      mem_wdata;
  logic               mem_read_valid;
  logic               mem_write_valid;
  logic [LS-1:0]      mem_rdata;
  logic [1:0]         grant_id;
  logic               timeout_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_line_arbiter #(
    .NB_PORTS       (NP),
    .LINE_SIZE      (LS),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .req_read_en_i     (req_read_en),
    .req_write_en_i    (req_write_en),
    .req_addr_i        (req_addr),
    .req_write_data_i  (req_wdata),
    .req_read_valid_o  (req_read_valid),
    .req_write_valid_o (req_write_valid),
    .req_read_data_o   (req_read_data),
    .mem_read_en_o     (mem_read_en),
    .mem_write_en_o    (mem_write_en),
    .mem_addr_o        (mem_addr),
    .mem_write_data_o  (mem_wdata),
    .mem_read_valid_i  (mem_read_valid),
    .mem_write_valid_i (mem_write_valid),
    .mem_read_data_i   (mem_rdata),
    .grant_id_o        (grant_id),
    .timeout_err_o     (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn            = 1'b0;
    req_read_en     = '0;
    req_write_en    = '0;
    req_addr        = '0;
    req_wdata       = '0;
    mem_read_valid  = 1'b0;
    mem_write_valid = 1'b0;
    mem_rdata       = '0;
    step();
    step();
    tests++;
    if ({mem_read_en, mem_write_en} !== 2'b00) begin
      fails++; $display("FAIL reset_mem_en: got %b exp 00", {mem_read_en, mem_write_en});
    end
    tests++;
    if ({req_read_valid, req_write_valid} !== 6'b0) begin
      fails++; $display("FAIL reset_valid: got %b exp 000000", {req_read_valid, req_write_valid});
    end
    tests++;
    if ({grant_id, timeout_err} !== 3'b000) begin
      fails++; $display("FAIL reset_grant_err: got %b exp 000", {grant_id, timeout_err});
    end
    tests++;
    if (mem_addr !== 32'h0 || req_read_data !== '0 || mem_wdata !== '0) begin
      fails++; $display("FAIL reset_data: addr %h exp 0", mem_addr);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    logic [LS-1:0] line;
    line = {8{32'hC0DE_0040}};
    mem_rdata      = line;
    req_addr[0]    = 32'h0001_0040;
    req_read_en    = 3'b001;
    step();
    tests++;
    if (mem_read_en !== 1'b1 || mem_addr !== 32'h0001_0040) begin
      fails++; $display("FAIL single_busy: en %b addr %h exp 1 00010040", mem_read_en, mem_addr);
    end
    step();
    step();
    tests++;
    if (req_read_valid !== 3'b000 || mem_read_en !== 1'b1) begin
      fails++; $display("FAIL single_wait: valid %b en %b exp 000 1", req_read_valid, mem_read_en);
    end
    mem_read_valid = 1'b1;
    step();
    mem_read_valid = 1'b0;
    req_read_en    = '0;
    tests++;
    if (req_read_valid !== 3'b001 || mem_read_en !== 1'b0) begin
      fails++; $display("FAIL single_resp: valid %b en %b exp 001 0", req_read_valid, mem_read_en);
    end
    tests++;
    if (req_read_data !== line) begin
      fails++; $display("FAIL single_data: got %h exp %h", req_read_data, line);
    end
    step();
    tests++;
    if (req_read_valid !== 3'b000) begin
      fails++; $display("FAIL single_pulse_len: got %b exp 000", req_read_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    logic [31:0] addrs [3];
    order = '{2'd0, 2'd1, 2'd2, 2'd0};
    addrs = '{32'h100, 32'h200, 32'h300};
    do_reset();
    for (int p = 0; p < 3; p++) req_addr[p] = addrs[p];
    mem_rdata      = {8{32'h1234_5678}};
    mem_read_valid = 1'b1;
    req_read_en    = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      tests++;
      if (mem_read_en !== 1'b1 || grant_id !== order[k] || mem_addr !== addrs[order[k]]) begin
        fails++;
        $display("FAIL rr_grant%0d: en %b grant %0d addr %h exp 1 %0d %h", k, mem_read_en,
                 grant_id, mem_addr, order[k], addrs[order[k]]);
      end
      step();
      tests++;
      if (req_read_valid !== (3'b001 << order[k])) begin
        fails++; $display("FAIL rr_pulse%0d: got %b exp %b", k, req_read_valid,
                          3'b001 << order[k]);
      end
      req_read_en[order[k]] = 1'b0;
      if (k == 1) req_read_en[0] = 1'b1;
      step();
      tests++;
      if (mem_read_en !== 1'b0 || req_read_valid !== 3'b000) begin
        fails++; $display("FAIL rr_idle%0d: en %b valid %b exp 0 000", k, mem_read_en,
                          req_read_valid);
      end
    end
    mem_read_valid = 1'b0;
  endtask

  task automatic test_read_write();
    logic [LS-1:0] wline, rline;
    wline = {8{32'hBEEF_0001}};
    rline = {8{32'h5555_AAAA}};
    req_addr[1]     = 32'h0002_0080;
    req_wdata[1]    = wline;
    mem_rdata       = rline;
    mem_write_valid = 1'b1;
    req_read_en     = 3'b010;
    req_write_en    = 3'b010;
    step();
    tests++;
    if ({mem_write_en, mem_read_en} !== 2'b10 || mem_wdata !== wline || grant_id !== 2'd1) begin
      fails++; $display("FAIL rw_write_busy: wr/rd %b grant %0d exp 10 1",
                        {mem_write_en, mem_read_en}, grant_id);
    end
    step();
    tests++;
    if (req_write_valid !== 3'b010 || req_read_valid !== 3'b000) begin
      fails++; $display("FAIL rw_write_pulse: wv %b rv %b exp 010 000", req_write_valid,
                        req_read_valid);
    end
    req_write_en    = '0;
    mem_write_valid = 1'b0;
    step();
    step();
    tests++;
    if ({mem_write_en, mem_read_en} !== 2'b01 || grant_id !== 2'd1) begin
      fails++; $display("FAIL rw_read_busy: wr/rd %b grant %0d exp 01 1",
                        {mem_write_en, mem_read_en}, grant_id);
    end
    mem_read_valid = 1'b1;
    step();
    tests++;
    if (req_read_valid !== 3'b010 || req_read_data !== rline) begin
      fails++; $display("FAIL rw_read_pulse: rv %b data %h exp 010 %h", req_read_valid,
                        req_read_data, rline);
    end
    req_read_en    = '0;
    mem_read_valid = 1'b0;
    step();
  endtask

  task automatic test_spurious();
    logic ok;
    mem_read_valid = 1'b1;
    step();
    step();
    tests++;
    if ({req_read_valid, req_write_valid} !== 6'b0 || {mem_read_en, mem_write_en} !== 2'b00) begin
      fails++; $display("FAIL spur_idle: valids %b en %b exp 0 0",
                        {req_read_valid, req_write_valid}, {mem_read_en, mem_write_en});
    end
    req_addr[2]  = 32'h0003_00C0;
    req_wdata[2] = {8{32'h0F0F_F0F0}};
    req_write_en = 3'b100;
    step();
    tests++;
    if ({mem_write_en, mem_read_en} !== 2'b10 || grant_id !== 2'd2 || mem_addr !== 32'h0003_00C0)
    begin
      fails++; $display("FAIL spur_busy: wr/rd %b grant %0d addr %h exp 10 2 000300c0",
                        {mem_write_en, mem_read_en}, grant_id, mem_addr);
    end
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (req_write_valid !== 3'b000 || req_read_valid !== 3'b000 || mem_write_en !== 1'b1)
        ok = 1'b0;
    end
    tests++;
    if (ok !== 1'b1) begin
      fails++; $display("FAIL spur_hold: got %b exp 1", ok);
    end
    mem_write_valid = 1'b1;
    step();
    tests++;
    if (req_write_valid !== 3'b100 || req_read_valid !== 3'b000) begin
      fails++; $display("FAIL spur_write_pulse: wv %b rv %b exp 100 000", req_write_valid,
                        req_read_valid);
    end
    req_write_en    = '0;
    mem_write_valid = 1'b0;
    mem_read_valid  = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    logic ok;
    req_addr[0] = 32'h0004_0000;
    req_read_en = 3'b001;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (mem_read_en !== 1'b1 || req_read_valid !== 3'b000) ok = 1'b0;
    end
    tests++;
    if (ok !== 1'b1) begin
      fails++; $display("FAIL tmo_en_window: got %b exp 1", ok);
    end
    step();
    req_read_en = '0;
    tests++;
    if (mem_read_en !== 1'b0 || req_read_valid !== 3'b001) begin
      fails++; $display("FAIL tmo_pulse: en %b rv %b exp 0 001", mem_read_en, req_read_valid);
    end
    tests++;
    if (req_read_data !== '0 || timeout_err !== 1'b1) begin
      fails++; $display("FAIL tmo_data_err: data %h err %b exp 0 1", req_read_data, timeout_err);
    end
    step();
    step();
    tests++;
    if (timeout_err !== 1'b1) begin
      fails++; $display("FAIL tmo_sticky: got %b exp 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    req_addr[1] = 32'h0005_0000;
    req_read_en = 3'b010;
    step();
    tests++;
    if (mem_read_en !== 1'b1 || grant_id !== 2'd1) begin
      fails++; $display("FAIL mid_busy: en %b grant %0d exp 1 1", mem_read_en, grant_id);
    end
    rstn        = 1'b0;
    req_read_en = '0;
    step();
    rstn = 1'b1;
    tests++;
    if ({mem_read_en, mem_write_en} !== 2'b00 || timeout_err !== 1'b0) begin
      fails++; $display("FAIL mid_abort: en %b err %b exp 00 0", {mem_read_en, mem_write_en},
                        timeout_err);
    end
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if ({req_read_valid, req_write_valid} !== 6'b0) ok = 1'b0;
      step();
    end
    tests++;
    if (ok !== 1'b1) begin
      fails++; $display("FAIL mid_no_pulse: got %b exp 1", ok);
    end
    req_read_en = 3'b111;
    step();
    tests++;
    if (mem_read_en !== 1'b1 || grant_id !== 2'd0) begin
      fails++; $display("FAIL mid_priority: en %b grant %0d exp 1 0", mem_read_en, grant_id);
    end
    req_read_en = '0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_write();
    test_spurious();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
